// File: rtl/cordic_scheduler.sv
// -----------------------------------------------------------------------------
// cordic_scheduler
//   Shares one pipelined CORDIC rotator among N_REQ requesters. A round-robin
//   arbiter admits at most one operand set per cycle. A tag shift register
//   follows each operation through the rotator and steers its x/y result back
//   to the requester that issued it. Per-requester credit counters limit the
//   number of operations a requester may have outstanding.
//
// Ports
//   clk                   clock, all state on posedge
//   rst                   synchronous reset, active-high
//   req_valid[N_REQ]      per-requester operand valid
//   req_ready[N_REQ]      one-hot grant (0 while rst is high or nobody eligible)
//   req_x/y/z[N_REQ*W]    packed operands, requester i at [i*W +: W]
//   cordic_x0/y0/z0[W]    registered operands driven into the CORDIC
//   cordic_x/y[W]         CORDIC results, LATENCY edges after cordic_*0
//   rsp_valid[N_REQ]      one-hot single-cycle result pulse, no backpressure
//   rsp_x/y[W]            result data, valid while any rsp_valid bit is high
//   busy                  work in flight, credits held, or response pending
// -----------------------------------------------------------------------------
module cordic_scheduler #(
  parameter int N_REQ   = 4,
  parameter int W       = 32,
  parameter int LATENCY = 17,
  parameter int MAX_OUT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_x,
  input  logic [N_REQ*W-1:0] req_y,
  input  logic [N_REQ*W-1:0] req_z,
  output logic [W-1:0]       cordic_x0,
  output logic [W-1:0]       cordic_y0,
  output logic [W-1:0]       cordic_z0,
  input  logic [W-1:0]       cordic_x,
  input  logic [W-1:0]       cordic_y,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_x,
  output logic [W-1:0]       rsp_y,
  output logic               busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);
  localparam logic [IW-1:0] LAST_ID = IW'(N_REQ - 1);

  // Arbitration / credit state
  logic [IW-1:0]    r_ptr;
  logic [CW-1:0]    r_cnt [N_REQ];

  // Operand registers feeding the rotator
  logic [W-1:0]     r_x0, r_y0, r_z0;

  // Tag pipe. The stage-0 tag is loaded together with the operand registers;
  // the LATENCY-entry shift register behind it keeps the tail entry aligned
  // with cordic_x/y.
  logic             r_tag0_vld;
  logic [IW-1:0]    r_tag0_id;
  logic [LATENCY-1:0] r_tag_vld;
  logic [IW-1:0]    r_tag_id [LATENCY];

  // Response registers
  logic [N_REQ-1:0] r_rsp_valid;
  logic [W-1:0]     r_rsp_x, r_rsp_y;

  // Combinational arbitration results
  logic [N_REQ-1:0] w_eligible;
  logic             w_grant_vld;
  logic [IW-1:0]    w_grant_id;
  logic [N_REQ-1:0] w_grant_oh;
  logic [IW-1:0]    w_ptr_next;
  logic             w_tail_vld;
  logic [IW-1:0]    w_tail_id;
  logic [N_REQ-1:0] w_tail_oh;
  logic             w_cnt_any;

  assign w_tail_vld = r_tag_vld[LATENCY-1];
  assign w_tail_id  = r_tag_id[LATENCY-1];

  // NOTE: every signal written here gets a default before any conditional
  // assignment, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_eligible  = '0;
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    w_grant_oh  = '0;
    w_tail_oh   = '0;
    w_cnt_any   = 1'b0;

    for (int i = 0; i < N_REQ; i++) begin
      w_eligible[i] = req_valid[i] && (r_cnt[i] < MAX_CNT);
      w_cnt_any     = w_cnt_any || (r_cnt[i] != '0);
    end

    // First eligible index scanning from the round-robin pointer, wrapping.
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_grant_vld && w_eligible[(int'(r_ptr) + k) % N_REQ]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = IW'((int'(r_ptr) + k) % N_REQ);
      end
    end

    // No handshake may complete on a reset edge.
    if (rst) begin
      w_grant_vld = 1'b0;
    end

    if (w_grant_vld) begin
      w_grant_oh[w_grant_id] = 1'b1;
    end
    if (w_tail_vld) begin
      w_tail_oh[w_tail_id] = 1'b1;
    end
  end

  // Explicit wrap keeps N_REQ values that are not a power of two correct.
  assign w_ptr_next = (w_grant_id == LAST_ID) ? '0 : w_grant_id + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_x0        <= '0;
      r_y0        <= '0;
      r_z0        <= '0;
      r_tag0_vld  <= 1'b0;
      r_tag_vld   <= '0;
      r_rsp_valid <= '0;
      r_rsp_x     <= '0;
      r_rsp_y     <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      if (w_grant_vld) begin
        r_x0  <= req_x[int'(w_grant_id)*W +: W];
        r_y0  <= req_y[int'(w_grant_id)*W +: W];
        r_z0  <= req_z[int'(w_grant_id)*W +: W];
        r_ptr <= w_ptr_next;
      end

      r_tag0_vld <= w_grant_vld;
      r_tag_vld  <= {r_tag_vld[LATENCY-2:0], r_tag0_vld};

      r_rsp_valid <= w_tail_oh;
      if (w_tail_vld) begin
        r_rsp_x <= cordic_x;
        r_rsp_y <= cordic_y;
      end

      // A grant and a response to the same requester on one edge cancel.
      for (int i = 0; i < N_REQ; i++) begin
        if (w_grant_oh[i] && !w_tail_oh[i]) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (!w_grant_oh[i] && w_tail_oh[i]) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

  // NOTE: the tag id pipe is payload qualified by r_tag*_vld, so it carries
  // no reset; clearing the valid bits is enough to discard in-flight work.
  always_ff @(posedge clk) begin
    r_tag0_id   <= w_grant_id;
    r_tag_id[0] <= r_tag0_id;
    for (int i = 1; i < LATENCY; i++) begin
      r_tag_id[i] <= r_tag_id[i-1];
    end
  end

  assign req_ready = w_grant_oh;
  assign cordic_x0 = r_x0;
  assign cordic_y0 = r_y0;
  assign cordic_z0 = r_z0;
  assign rsp_valid = r_rsp_valid;
  assign rsp_x     = r_rsp_x;
  assign rsp_y     = r_rsp_y;
  assign busy      = r_tag0_vld || (|r_tag_vld) || w_cnt_any || (|r_rsp_valid);

endmodule

// File: tb/tb_cordic_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cordic_scheduler
//   Drives the scheduler with directed and random request patterns. A stand-in
//   rotator (fixed mixing function behind a 17-stage delay) sits on the CORDIC
//   side. The reference model tracks the round-robin pointer, per-requester
//   credits and a queue of expected responses with their due edge.
// -----------------------------------------------------------------------------
module tb_cordic_scheduler;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 17;
  localparam int MO  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_x, req_y, req_z;
  logic [W-1:0]   cordic_x0, cordic_y0, cordic_z0;
  logic [W-1:0]   cordic_x, cordic_y;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_x, rsp_y;
  logic           busy;

  always #5 clk = ~clk;

  cordic_scheduler #(.N_REQ(N), .W(W), .LATENCY(LAT), .MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .cordic_x0(cordic_x0), .cordic_y0(cordic_y0), .cordic_z0(cordic_z0),
    .cordic_x(cordic_x), .cordic_y(cordic_y),
    .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y),
    .busy(busy)
  );

  // Stand-in rotator: any fixed function works, the scheduler never looks at data.
  function automatic logic [W-1:0] rot_x(input logic [W-1:0] x, y, z);
    return (x ^ {z[15:0], z[31:16]}) + 32'h0000_1357 - (y >>> 2);
  endfunction

  function automatic logic [W-1:0] rot_y(input logic [W-1:0] x, y, z);
    return (y - {z[31], z[31:1]}) ^ {x[7:0], x[31:8]};
  endfunction

  logic [W-1:0] sp_x [LAT];
  logic [W-1:0] sp_y [LAT];

  always_ff @(posedge clk) begin
    sp_x[0] <= rot_x(cordic_x0, cordic_y0, cordic_z0);
    sp_y[0] <= rot_y(cordic_x0, cordic_y0, cordic_z0);
    for (int i = 1; i < LAT; i++) begin
      sp_x[i] <= sp_x[i-1];
      sp_y[i] <= sp_y[i-1];
    end
  end

  assign cordic_x = sp_x[LAT-1];
  assign cordic_y = sp_y[LAT-1];

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int           id;
    logic [W-1:0] x;
    logic [W-1:0] y;
    int           due;   // edge number after which rsp_valid is high
  } exp_t;

  exp_t q[$];
  int   m_ptr;
  int   m_cnt [N];
  int   edge_n;
  int   n_grants [N];

  task automatic model_reset();
    q.delete();
    m_ptr = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance model.
  task automatic step(input logic [N-1:0] vmask, input logic do_rst, input logic rnd_data);
    int           g;
    logic [N-1:0] exp_ready;
    logic         exp_busy;
    exp_t         e;

    rst       = do_rst;
    req_valid = vmask;
    if (rnd_data) begin
      for (int i = 0; i < N; i++) begin
        req_x[i*W +: W] = $urandom();
        req_y[i*W +: W] = $urandom();
        req_z[i*W +: W] = $urandom();
      end
    end

    @(negedge clk);

    // Outputs reflecting the state after edge edge_n.
    exp_busy = (q.size() > 0);
    for (int i = 0; i < N; i++) exp_busy = exp_busy || (m_cnt[i] != 0);
    check("busy", 64'(busy), 64'(exp_busy));

    if (q.size() > 0 && q[0].due == edge_n) begin
      e = q.pop_front();
      check("rsp_valid", 64'(rsp_valid), 64'(1 << e.id));
      check("rsp_x", 64'(rsp_x), 64'(e.x));
      check("rsp_y", 64'(rsp_y), 64'(e.y));
    end else begin
      check("rsp_valid_idle", 64'(rsp_valid), 64'd0);
    end

    // Expected grant for the coming edge.
    g = -1;
    if (!do_rst) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (g < 0 && vmask[idx] && m_cnt[idx] < MO) g = idx;
      end
    end
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    check("req_ready", 64'(req_ready), 64'(exp_ready));

    // Advance model across the coming edge.
    if (do_rst) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        m_cnt[g]++;
        n_grants[g]++;
        m_ptr = (g + 1) % N;
        e.id  = g;
        e.x   = rot_x(req_x[g*W +: W], req_y[g*W +: W], req_z[g*W +: W]);
        e.y   = rot_y(req_x[g*W +: W], req_y[g*W +: W], req_z[g*W +: W]);
        e.due = edge_n + 1 + LAT + 1;
        q.push_back(e);
      end
      if (q.size() > 0 && q[0].due == edge_n + 1) m_cnt[q[0].id]--;
    end

    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    req_z     = '0;
    edge_n    = 0;
    for (int i = 0; i < N; i++) n_grants[i] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_cordic_x0", 64'(cordic_x0), 64'd0);
    check("reset_rsp_x", 64'(rsp_x), 64'd0);
    check("reset_ready", 64'(req_ready), 64'd0);

    // Single op from requester 2 with fixed operands.
    req_x[2*W +: W] = 32'h0000_4DBA;
    req_y[2*W +: W] = 32'h0000_0000;
    req_z[2*W +: W] = 32'h0000_0324;
    step(4'b0100, 1'b0, 1'b0);
    check("single_x0", 64'(cordic_x0), 64'h4DBA);
    idle(LAT + 4);

    // Round-robin: everyone valid continuously.
    for (int i = 0; i < 12; i++) step(4'b1111, 1'b0, 1'b1);
    idle(LAT + 4);

    // Credit limit: requester 1 alone, always valid.
    for (int i = 0; i < N; i++) n_grants[i] = 0;
    for (int i = 0; i < 3 * (LAT + 1); i++) step(4'b0010, 1'b0, 1'b1);
    check("credit_grants", 64'(n_grants[1]), 64'(3 * MO));
    idle(LAT + 4);

    // Pointer wrap: park pointer at 3, then only 3 and 0 valid.
    step(4'b0100, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b1001, 1'b0, 1'b1);
    idle(LAT + 4);

    // Reset mid-flight: five ops, reset at cycle 8, nothing may come back.
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b0, 1'b1);
    idle(2);
    step(4'b1111, 1'b1, 1'b1);
    check("post_rst_busy", 64'(busy), 64'd0);
    idle(LAT + 4);
    step(4'b1111, 1'b0, 1'b1);   // pointer back at 0: requester 0 first
    idle(LAT + 4);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] m;
      m = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : 4'b1111 & N'($urandom());
      step(m, ($urandom_range(0, 199) == 0), 1'b1);
    end
    idle(LAT + 4);
    check("final_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
